adc_scan_sequencer: RTL

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: periodically walks the enabled channels of an LTC2308-style
// SPI ADC engine, interleaves host single-shot conversions, and reports results,
// end-of-scan strobes and sticky timeout/overrun flags.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; cmd_valid/cmd_data and oneshot_valid/oneshot_channel are held
// unchanged by their source until that edge.
module adc_scan_sequencer #(
    parameter int NCHANNELS = 8,
    parameter int DWIDTH    = 12,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NCHANNELS-1:0] channel_mask,
    input  logic [15:0]          period_cycles,
    input  logic                 clear_err,
    input  logic                 oneshot_valid,
    input  logic [2:0]           oneshot_channel,
    output logic                 oneshot_ready,
    output logic                 cmd_valid,
    output logic [5:0]           cmd_data,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [DWIDTH-1:0]    rsp_data,
    output logic                 result_valid,
    output logic [DWIDTH-1:0]    result_data,
    output logic [2:0]           result_channel,
    output logic                 result_oneshot,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT, NEXT} state_t;

    state_t                 state, state_next;
    logic [15:0]            period_cnt;
    logic [15:0]            period_load;
    logic [TW-1:0]          tmo_cnt;
    logic                   tick;
    logic                   scan_active, scan_pending;
    logic [NCHANNELS-1:0]   scan_mask;
    logic [2:0]             cur_ch, conv_ch, low_ch, next_ch;
    logic                   conv_oneshot, next_found;
    logic                   start_req, start_scan, step_scan, end_scan, take_oneshot;
    logic                   timeout_fire;

    // Periods of 0 and 1 both collapse to a tick on every cycle.
    assign period_load  = (period_cycles == 16'd0) ? 16'd0 : period_cycles - 16'd1;
    assign tick         = enable && (state != IDLE) && (period_cnt == 16'd0);
    // A scan may start from a fresh tick or from one held back behind a oneshot.
    assign start_req    = (scan_pending || (tick && !scan_active)) && (channel_mask != '0);
    assign timeout_fire = (state == WAIT) && !rsp_valid && (tmo_cnt == '0);

    assign cmd_valid = (state == ISSUE);
    assign cmd_data  = (state == ISSUE) ? {1'b1, conv_ch[0], conv_ch[2:1], 1'b1, 1'b0} : 6'd0;
    assign busy      = (state == ISSUE) || (state == WAIT) || (state == NEXT);

    // Lowest set bit of the live mask (scan start) and next set bit above the scan position.
    always_comb begin
        low_ch     = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NCHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i]) low_ch = 3'(i);
            if (scan_mask[i] && (i > int'(cur_ch))) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_next    = state;
        oneshot_ready = 1'b0;
        take_oneshot  = 1'b0;
        start_scan    = 1'b0;
        step_scan     = 1'b0;
        end_scan      = 1'b0;
        case (state)
            IDLE: if (enable) state_next = ARM;
            ARM: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (oneshot_valid) begin
                    oneshot_ready = 1'b1;
                    take_oneshot  = 1'b1;
                    state_next    = ISSUE;
                end else if (start_req) begin
                    start_scan = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: if (cmd_ready) state_next = WAIT;
            WAIT:  if (rsp_valid || timeout_fire) state_next = NEXT;
            NEXT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (oneshot_valid) begin
                    oneshot_ready = 1'b1;
                    take_oneshot  = 1'b1;
                    state_next    = ISSUE;
                end else if (scan_active && next_found) begin
                    step_scan  = 1'b1;
                    state_next = ISSUE;
                end else if (scan_active) begin
                    end_scan   = 1'b1;
                    state_next = ARM;
                end else if (start_req) begin
                    start_scan = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Free-running scan period counter, reloaded on entry to ARM and on every tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (enable) begin
            if (state == IDLE || period_cnt == 16'd0) period_cnt <= period_load;
            else                                      period_cnt <= period_cnt - 16'd1;
        end
    end

    // Response timeout counter, armed by the command handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE && cmd_ready) begin
            tmo_cnt <= TW'(TIMEOUT - 1);
        end else if (state == WAIT && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Scan bookkeeping: snapshot of the mask, scan position and channel in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_active  <= 1'b0;
            scan_pending <= 1'b0;
            scan_mask    <= '0;
            cur_ch       <= '0;
            conv_ch      <= '0;
            conv_oneshot <= 1'b0;
        end else begin
            if (start_scan) begin
                scan_active  <= 1'b1;
                scan_pending <= 1'b0;
                scan_mask    <= channel_mask;
                cur_ch       <= low_ch;
                conv_ch      <= low_ch;
                conv_oneshot <= 1'b0;
            end else begin
                if (end_scan || state_next == IDLE) scan_active <= 1'b0;
                if (state_next == IDLE) scan_pending <= 1'b0;
                else if (tick && !scan_active && channel_mask != '0) scan_pending <= 1'b1;
                if (step_scan) begin
                    cur_ch       <= next_ch;
                    conv_ch      <= next_ch;
                    conv_oneshot <= 1'b0;
                end else if (take_oneshot) begin
                    conv_ch      <= oneshot_channel;
                    conv_oneshot <= 1'b1;
                end
            end
        end
    end

    // Result strobe one cycle after the engine response, plus end-of-scan strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid   <= 1'b0;
            result_data    <= '0;
            result_channel <= '0;
            result_oneshot <= 1'b0;
            scan_done      <= 1'b0;
        end else begin
            result_valid <= (state == WAIT) && rsp_valid;
            scan_done    <= end_scan;
            if (state == WAIT && rsp_valid) begin
                result_data    <= rsp_data;
                result_channel <= conv_ch;
                result_oneshot <= conv_oneshot;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (timeout_fire)   timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
            if (tick && (scan_active || scan_pending)) overrun_err <= 1'b1;
            else if (clear_err)                         overrun_err <= 1'b0;
        end
    end

endmodule
